// File: rtl/branch_pred_checker_if.sv
// Branch-prediction check interface: IF-stage predictions and ID-stage
// resolutions in, redirect/desync pulses and accuracy counters out.
//   master : predictor/decoder side (drives pred_* and res_*)
//   slave  : branch_pred_checker (drives full, mispredict, redirect_pc,
//            desync, branch_count, mispred_count)
interface branch_pred_checker_if #(
    parameter int unsigned CNT_W = 32
);
    logic             pred_valid;
    logic [31:0]      pred_pc;
    logic             pred_taken;
    logic             res_valid;
    logic [31:0]      res_pc;
    logic             res_is_branch;
    logic             res_taken;
    logic [31:0]      res_target;
    logic             full;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             desync;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output pred_valid, pred_pc, pred_taken,
        output res_valid, res_pc, res_is_branch, res_taken, res_target,
        input  full, mispredict, redirect_pc, desync, branch_count, mispred_count
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken,
        input  res_valid, res_pc, res_is_branch, res_taken, res_target,
        output full, mispredict, redirect_pc, desync, branch_count, mispred_count
    );
endinterface

// File: rtl/branch_pred_checker.sv
// Records IF-stage predictions in a small FIFO and checks each against the
// ID-stage resolution of the oldest outstanding instruction. Wrong
// predictions raise a one-cycle mispredict with the corrected PC and flush
// all younger predictions; PC mismatches or resolutions on an empty queue
// raise desync and flush. Saturating branch/mispredict counters.
// Ports:
//   CLK   : clock, posedge
//   RESET : asynchronous active-low reset
//   bp    : branch_pred_checker_if.slave (prediction/resolution in,
//           full (combinational), mispredict/redirect_pc/desync pulses,
//           branch_count/mispred_count out)
module branch_pred_checker #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    branch_pred_checker_if.slave bp
);
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW   = AW + 1;
    localparam int unsigned PC_W = 32;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            taken;
    } pred_entry_t;

    pred_entry_t      mem_q [DEPTH];
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             mispredict_q, mispredict_d;
    logic             desync_q, desync_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    pred_entry_t head;
    logic        empty, full_c;
    logic        res_hit, wrong, flush, pop, push;

    // Decode of this cycle's resolution and push against the queue head
    always_comb begin
        head    = mem_q[rd_q];
        empty   = (occ_q == OW'(0));
        full_c  = (occ_q == OW'(DEPTH));

        desync_d = bp.res_valid && (empty || (head.pc != bp.res_pc));
        res_hit  = bp.res_valid && !empty && (head.pc == bp.res_pc);
        // A non-branch predicted taken is as wrong as a direction miss
        wrong    = res_hit && (bp.res_is_branch ? (head.taken != bp.res_taken)
                                                : head.taken);
        flush    = desync_d || wrong;
        pop      = res_hit && !wrong;
        push     = bp.pred_valid && !flush && (!full_c || pop);
    end

    // Next-state for pointers, pulses and counters
    always_comb begin
        rd_d         = rd_q;
        wr_d         = wr_q;
        occ_d        = occ_q;
        mispredict_d = wrong;
        redirect_d   = redirect_q;
        bcnt_d       = bcnt_q;
        mcnt_d       = mcnt_q;

        if (flush) begin
            rd_d  = wr_q;
            occ_d = OW'(0);
        end else begin
            if (pop)  rd_d = rd_q + AW'(1);
            if (push) wr_d = wr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   occ_d = occ_q + OW'(1);
                2'b01:   occ_d = occ_q - OW'(1);
                default: occ_d = occ_q;
            endcase
        end

        if (wrong) begin
            redirect_d = (bp.res_is_branch && bp.res_taken) ? bp.res_target
                                                            : bp.res_pc + PC_W'(4);
            if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
        end

        if (res_hit && bp.res_is_branch && (bcnt_q != '1))
            bcnt_d = bcnt_q + CNT_W'(1);
    end

    // State registers
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rd_q         <= '0;
            wr_q         <= '0;
            occ_q        <= '0;
            mispredict_q <= 1'b0;
            desync_q     <= 1'b0;
            redirect_q   <= '0;
            bcnt_q       <= '0;
            mcnt_q       <= '0;
        end else begin
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            occ_q        <= occ_d;
            mispredict_q <= mispredict_d;
            desync_q     <= desync_d;
            redirect_q   <= redirect_d;
            bcnt_q       <= bcnt_d;
            mcnt_q       <= mcnt_d;
        end
    end

    // Prediction storage
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_q] <= '{pc: bp.pred_pc, taken: bp.pred_taken};
        end
    end

    assign bp.full          = full_c;
    assign bp.mispredict    = mispredict_q;
    assign bp.desync        = desync_q;
    assign bp.redirect_pc   = redirect_q;
    assign bp.branch_count  = bcnt_q;
    assign bp.mispred_count = mcnt_q;
endmodule

// File: doc/branch_pred_checker.md
Name: branch_pred_checker

Overview:
- Consumer end of the branch-prediction interface: records each IF-stage prediction, then checks it against the ID-stage branch resolution.
- On a wrong prediction it raises a one-cycle mispredict/redirect to the fetch unit and discards all younger (wrong-path) predictions.
- Keeps saturating branch and mispredict counters for accuracy measurement.
- Sits between the predictor output and the IF/ID redirect logic.

Parameters:
- DEPTH, 4, prediction queue entries (power of 2, ≥2)
- CNT_W, 32, width of the statistics counters

Ports:
- CLK  in  1  clock, all state updates on posedge
- RESET  in  1  asynchronous, active-low reset
- pred_valid  in  1  IF stage issues a prediction this cycle
- pred_pc  in  32  PC of the predicted instruction
- pred_taken  in  1  predicted direction
- res_valid  in  1  ID stage resolves the oldest outstanding instruction
- res_pc  in  32  PC of the resolving instruction
- res_is_branch  in  1  resolving instruction is a conditional branch
- res_taken  in  1  actual direction
- res_target  in  32  actual taken target
- full  out  1  queue full, combinational from occupancy
- mispredict  out  1  registered one-cycle pulse
- redirect_pc  out  32  correct next PC, valid when mispredict=1
- desync  out  1  registered one-cycle pulse: res_pc ≠ head PC, or resolution with empty queue
- branch_count  out  CNT_W  resolved branches, saturating
- mispred_count  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (async, RESET=0): queue empty; rd/wr pointers=0; mispredict=0, desync=0, redirect_pc=0, both counters=0; full=0.
- Queue: circular FIFO of {pc, taken}. Pointers wrap modulo DEPTH. Occupancy counter 0..DEPTH.
- Push: occurs when pred_valid=1 and (not full, or a non-flushing pop happens the same cycle). pred_valid while full with no pop: prediction dropped, no error.
- Resolution (res_valid=1):
  - Queue empty: desync=1 next cycle; no pop; counters unchanged.
  - head.pc ≠ res_pc: desync=1; flush the entire queue; counters unchanged.
  - head.pc = res_pc: pop head; evaluate:
    - res_is_branch=1: branch_count+1. If head.taken ≠ res_taken, the prediction is wrong: mispredict=1, mispred_count+1, and redirect_pc = res_taken ? res_target : res_pc+4.
    - res_is_branch=0 and head.taken=1: the prediction is wrong: mispredict=1, mispred_count+1, redirect_pc=res_pc+4. branch_count is not incremented.
    - Otherwise: prediction correct, pop only.
- Flush: on any mispredict or desync, all entries are invalidated in the same edge (occupancy=0, rd=wr). A same-cycle push is dropped; flush wins.
- Same-cycle push and pop without flush: occupancy unchanged; both pointers advance. This is legal when full.
- Latency: mispredict, desync and redirect_pc are registered, 1 cycle after the res_valid edge. Each pulse lasts exactly one cycle unless retriggered next cycle.
- Counters: saturate at 2^CNT_W−1 and never wrap.
- redirect_pc holds its last value when mispredict=0.
- res_pc+4 uses 32-bit modulo arithmetic: 0xFFFFFFFC+4 = 0.
- Reset mid-operation: queue contents, pending pulses and counters cleared immediately.

Test Plan:
1. Reset, then push {0x100,T}, {0x104,N}. Resolve 0x100 taken branch, then 0x104 not-taken branch → no mispredict, branch_count=2, mispred_count=0, queue empty.
2. Push {0x200,N}, {0x204,T}, {0x208,N}. Resolve 0x200 taken, target 0x400 → next cycle mispredict=1, redirect_pc=0x400, mispred_count=1, occupancy=0. Following cycle mispredict=0.
3. Push {0x300,T}. Resolve 0x300, res_is_branch=0 → mispredict=1, redirect_pc=0x304, branch_count unchanged. Resolution with empty queue → desync=1, counters unchanged.
4. Fill DEPTH=4 entries, full=1. Assert pred_valid without resolve → dropped, occupancy 4. Next cycle push+correct resolve → occupancy stays 4, order preserved on later pops.
5. Push {0x500,N}. Resolve res_pc=0x504 → desync=1, queue flushed. Same-cycle push of 0x508 dropped.
6. Force counters to 0xFFFFFFFF and resolve a mispredicted branch → both stay 0xFFFFFFFF. Assert RESET=0 asynchronously mid-cycle → all outputs 0 immediately.
